// File: rtl/mda_attr_shifter_if.sv
// Character-cell bus between the MDA text timing front end and the pixel shifter.
// The master supplies the per-cell glyph/attribute data and strobes; the slave returns the pixel flags.
interface mda_attr_shifter_if;
   logic       pix_en;
   logic       load;
   logic       disp_en;
   logic [7:0] char_code;
   logic [7:0] attr;
   logic [7:0] font_row;
   logic       cursor;
   logic       underline_row;
   logic       frame_tick;
   logic       video;
   logic       intensity;

   modport master (
      output pix_en, load, disp_en, char_code, attr, font_row,
             cursor, underline_row, frame_tick,
      input  video, intensity
   );

   modport slave (
      input  pix_en, load, disp_en, char_code, attr, font_row,
             cursor, underline_row, frame_tick,
      output video, intensity
   );
endinterface

// File: rtl/mda_attr_shifter.sv
// MDA 9-dot character shifter with attribute, cursor and blink decode.
// Pixel out 1 clk after its pix_en edge (column 0 at the load edge); pix_en=0 freezes everything but the frame counter.
module mda_attr_shifter #(
   parameter int BLINK_BITS = 5
) (
   input logic             clk,
   input logic             reset,
   mda_attr_shifter_if.slave bus
);

   localparam logic [3:0] COL_LAST = 4'd8;
   localparam logic [3:0] COL_IDLE = 4'd9;

   logic [8:0]            shreg;
   logic [3:0]            col;
   logic [7:0]            attr_q;
   logic                  cur_q;
   logic                  ul_q;
   logic                  de_q;
   logic                  cph_q;
   logic                  bph_q;
   logic [BLINK_BITS-1:0] frame_cnt;

   logic                  cursor_phase;
   logic                  blink_phase;
   logic                  col9_bit;
   logic [8:0]            load_row;
   logic [1:0]            load_pix;
   logic [1:0]            next_pix;

   // Returns {video, intensity}; rule order matters, first match wins.
   function automatic logic [1:0] decode(
      input logic       b,
      input logic [7:0] a,
      input logic       de,
      input logic       cur,
      input logic       ul,
      input logic       cph,
      input logic       bph
   );
      logic v;
      logic rev;
      v   = 1'b0;
      rev = 1'b0;
      if (!de) begin
         v = 1'b0;
      end else if (cur && cph) begin
         v = 1'b1;
      end else if (a[2:0] == 3'b000 && a[6:4] == 3'b111) begin
         rev = 1'b1;
         v   = ~b & ~(a[7] & bph);
      end else if (a[2:0] == 3'b000) begin
         v = 1'b0;
      end else if (a[2:0] == 3'b001 && ul) begin
         v = 1'b1;
      end else begin
         v = b & ~(a[7] & bph);
      end
      return {v, (rev ? 1'b0 : (a[3] & v))};
   endfunction

   assign cursor_phase = frame_cnt[BLINK_BITS-2];
   assign blink_phase  = frame_cnt[BLINK_BITS-1];

   // Line-graphics codes 0xC0-0xDF stretch the rightmost glyph dot into the 9th column.
   assign col9_bit = (bus.char_code[7:5] == 3'b110) ? bus.font_row[0] : 1'b0;
   assign load_row = {bus.font_row, col9_bit};

   assign load_pix = decode(load_row[8], bus.attr, bus.disp_en, bus.cursor,
                            bus.underline_row, cursor_phase, blink_phase);
   assign next_pix = decode(shreg[7], attr_q, de_q, cur_q, ul_q, cph_q, bph_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg         <= '0;
         col           <= COL_IDLE;
         attr_q        <= '0;
         cur_q         <= 1'b0;
         ul_q          <= 1'b0;
         de_q          <= 1'b0;
         cph_q         <= 1'b0;
         bph_q         <= 1'b0;
         frame_cnt     <= '0;
         bus.video     <= 1'b0;
         bus.intensity <= 1'b0;
      end else begin
         if (bus.frame_tick) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (bus.pix_en) begin
            if (bus.load) begin
               // Phases are frozen here so a tick in this cycle only affects later cells.
               shreg         <= load_row;
               col           <= 4'd0;
               attr_q        <= bus.attr;
               cur_q         <= bus.cursor;
               ul_q          <= bus.underline_row;
               de_q          <= bus.disp_en;
               cph_q         <= cursor_phase;
               bph_q         <= blink_phase;
               bus.video     <= load_pix[1];
               bus.intensity <= load_pix[0];
            end else if (col < COL_LAST) begin
               col           <= col + 1'b1;
               shreg         <= {shreg[7:0], 1'b0};
               bus.video     <= next_pix[1];
               bus.intensity <= next_pix[0];
            end else begin
               col           <= COL_IDLE;
               bus.video     <= 1'b0;
               bus.intensity <= 1'b0;
            end
         end
      end
   end

endmodule
